// File: rtl/adc_scan_capture_if.sv
// SPI bus between the scan capture block (master) and an ADC128S022-type converter (slave).
interface adc_scan_capture_if;
  logic iADC_DOUT;
  logic oADC_CS_N;
  logic oADC_SCLK;
  logic oADC_DIN;

  modport master (
    input  iADC_DOUT,
    output oADC_CS_N,
    output oADC_SCLK,
    output oADC_DIN
  );

  modport slave (
    output iADC_DOUT,
    input  oADC_CS_N,
    input  oADC_SCLK,
    input  oADC_DIN
  );
endinterface

// File: rtl/adc_scan_capture.sv
// Scans Vin/Vout/Iout/Temp on an ADC128S022-type SPI ADC and publishes the top 8 bits as hex nibbles.
// Build macro ADC_SCAN_AVG_EN: commit a floor average of 4 scans instead of every raw scan.
module adc_scan_capture #(
  parameter int unsigned CLK_DIV     = 25,
  parameter int unsigned SCAN_PERIOD = 12500000,
  parameter logic [2:0]  CH_VIN      = 3'd0,
  parameter logic [2:0]  CH_VOUT     = 3'd1,
  parameter logic [2:0]  CH_IOUT     = 3'd2,
  parameter logic [2:0]  CH_TEMP     = 3'd3
) (
  input  logic               iCLK_50MHZ,
  input  logic               iRST_N,
  adc_scan_capture_if.master adc,
  output logic [3:0]         VinH,
  output logic [3:0]         VinL,
  output logic [3:0]         VoutH,
  output logic [3:0]         VoutL,
  output logic [3:0]         IoutH,
  output logic [3:0]         IoutL,
  output logic [3:0]         TempH,
  output logic [3:0]         TempL,
  output logic               oVALID,
  output logic               oBUSY,
  output logic [2:0]         dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_SHIFT  = 3'd2,
    S_STOP   = 3'd3,
    S_COMMIT = 3'd4
  } state_e;

  localparam int unsigned       IDLE_W     = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(SCAN_PERIOD - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);
  localparam logic [7:0]        DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [2:0]        LAST_FRAME = 3'd4;

  state_e            state_q, state_d;
  logic [7:0]        div_q, div_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [3:0]        bit_q, bit_d;
  logic              phase_q, phase_d;     // 0: SCLK low half, 1: SCLK high half
  logic [2:0]        frame_q, frame_d;
  logic [15:0]       rx_q, rx_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              din_q, din_d;
  logic              valid_q;
  logic              frame_done;
  logic              div_done;
  logic [2:0]        addr;
  logic [15:0]       tx_word;
  logic [7:0]        rx_result;
  logic [7:0]        vin_q, vout_q, iout_q, temp_q;
`ifdef ADC_SCAN_AVG_EN
  logic [1:0]        scan_q, scan_d;
  logic [9:0]        acc_vin_q, acc_vout_q, acc_iout_q, acc_temp_q;
`else
  logic [7:0]        sh_vin_q, sh_vout_q, sh_iout_q, sh_temp_q;
`endif

  // Frame 4 repeats the Temp address only to clock out Temp's frame-3 conversion.
  always_comb begin
    case (frame_q)
      3'd0:    addr = CH_VIN;
      3'd1:    addr = CH_VOUT;
      3'd2:    addr = CH_IOUT;
      default: addr = CH_TEMP;
    endcase
  end

  assign tx_word   = {2'b00, addr, 11'b0};
  assign rx_result = rx_q[11:4];
  assign div_done  = (div_q == DIV_LAST);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    idle_d     = idle_q;
    bit_d      = bit_q;
    phase_d    = phase_q;
    frame_d    = frame_q;
    rx_d       = rx_q;
    frame_done = 1'b0;
`ifdef ADC_SCAN_AVG_EN
    scan_d     = scan_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (idle_q == IDLE_LAST) begin
          state_d = S_START;
          idle_d  = '0;
          div_d   = '0;
          frame_d = '0;
        end else begin
          idle_d = idle_q + IDLE_ONE;
        end
      end
      S_START: begin
        if (div_done) begin
          state_d = S_SHIFT;
          div_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_SHIFT: begin
        if (div_done) begin
          div_d = '0;
          if (!phase_q) begin
            // This edge raises SCLK, so the ADC bit is captured here.
            phase_d = 1'b1;
            rx_d    = {rx_q[14:0], adc.iADC_DOUT};
          end else begin
            phase_d = 1'b0;
            if (bit_q == 4'd15) begin
              state_d    = S_STOP;
              frame_done = 1'b1;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_STOP: begin
        if (div_done) begin
          div_d   = '0;
          frame_d = frame_q + 3'd1;
          if (frame_q != LAST_FRAME) begin
            state_d = S_START;
          end else begin
`ifdef ADC_SCAN_AVG_EN
            scan_d  = scan_q + 2'd1;
            state_d = (scan_q == 2'd3) ? S_COMMIT : S_IDLE;
`else
            state_d = S_COMMIT;
`endif
            idle_d  = '0;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        idle_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // Pins are registered from the next state; DIN only moves when SCLK falls.
    cs_n_d = ~((state_d == S_START) || (state_d == S_SHIFT));
    sclk_d = ~((state_d == S_SHIFT) && !phase_d);
    din_d  = (state_d == S_SHIFT) ? tx_word[~bit_d] : 1'b0;
  end

  always_ff @(posedge iCLK_50MHZ) begin
    if (!iRST_N) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      idle_q  <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      frame_q <= '0;
      rx_q    <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      din_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idle_q  <= idle_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      frame_q <= frame_d;
      rx_q    <= rx_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      din_q   <= din_d;
      valid_q <= (state_d == S_COMMIT);
    end
  end

  // Each frame carries the conversion addressed one frame earlier, hence the f-1 mapping.
`ifdef ADC_SCAN_AVG_EN
  always_ff @(posedge iCLK_50MHZ) begin
    if (!iRST_N) begin
      scan_q     <= '0;
      acc_vin_q  <= '0;
      acc_vout_q <= '0;
      acc_iout_q <= '0;
      acc_temp_q <= '0;
      vin_q      <= '0;
      vout_q     <= '0;
      iout_q     <= '0;
      temp_q     <= '0;
    end else begin
      scan_q <= scan_d;
      if (frame_done) begin
        case (frame_q)
          3'd1:    acc_vin_q  <= acc_vin_q  + {2'b00, rx_result};
          3'd2:    acc_vout_q <= acc_vout_q + {2'b00, rx_result};
          3'd3:    acc_iout_q <= acc_iout_q + {2'b00, rx_result};
          3'd4:    acc_temp_q <= acc_temp_q + {2'b00, rx_result};
          default: ;
        endcase
      end
      if (state_d == S_COMMIT) begin
        vin_q      <= acc_vin_q[9:2];
        vout_q     <= acc_vout_q[9:2];
        iout_q     <= acc_iout_q[9:2];
        temp_q     <= acc_temp_q[9:2];
        acc_vin_q  <= '0;
        acc_vout_q <= '0;
        acc_iout_q <= '0;
        acc_temp_q <= '0;
      end
    end
  end
`else
  always_ff @(posedge iCLK_50MHZ) begin
    if (!iRST_N) begin
      sh_vin_q  <= '0;
      sh_vout_q <= '0;
      sh_iout_q <= '0;
      sh_temp_q <= '0;
      vin_q     <= '0;
      vout_q    <= '0;
      iout_q    <= '0;
      temp_q    <= '0;
    end else begin
      if (frame_done) begin
        case (frame_q)
          3'd1:    sh_vin_q  <= rx_result;
          3'd2:    sh_vout_q <= rx_result;
          3'd3:    sh_iout_q <= rx_result;
          3'd4:    sh_temp_q <= rx_result;
          default: ;
        endcase
      end
      if (state_d == S_COMMIT) begin
        vin_q  <= sh_vin_q;
        vout_q <= sh_vout_q;
        iout_q <= sh_iout_q;
        temp_q <= sh_temp_q;
      end
    end
  end
`endif

  // oVALID is a one-cycle strobe with no ready: the nibbles it marks hold until the next strobe.
  assign oVALID        = valid_q;
  assign oBUSY         = (state_q != S_IDLE);
  assign dbg_state_o   = state_q;
  assign adc.oADC_CS_N = cs_n_q;
  assign adc.oADC_SCLK = sclk_q;
  assign adc.oADC_DIN  = din_q;

  assign VinH  = vin_q[7:4];
  assign VinL  = vin_q[3:0];
  assign VoutH = vout_q[7:4];
  assign VoutL = vout_q[3:0];
  assign IoutH = iout_q[7:4];
  assign IoutL = iout_q[3:0];
  assign TempH = temp_q[7:4];
  assign TempL = temp_q[3:0];

endmodule

// File: tb/tb_adc_scan_capture.sv
// Bench for adc_scan_capture: SPI ADC model, per-scan vector table, mid-frame reset and averaging sequences.
module tb_adc_scan_capture;
  localparam int CLK_DIV     = 2;
  localparam int SCAN_PERIOD = 10;
`ifdef ADC_SCAN_AVG_EN
  localparam int NS = 4;
`else
  localparam int NS = 1;
`endif
  localparam int SCAN_CYC    = SCAN_PERIOD + 5 * 34 * CLK_DIV;
  localparam int FIRST_VALID = NS * SCAN_CYC;
  localparam int VALID_GAP   = NS * SCAN_CYC + 1;
  localparam int BUDGET      = 2 * VALID_GAP + 100;
  localparam int NV          = 8;

  typedef struct {
    logic [11:0] vin;
    logic [11:0] vout;
    logic [11:0] iout;
    logic [11:0] temp;
    logic [31:0] exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  VinH, VinL, VoutH, VoutL, IoutH, IoutL, TempH, TempL;
  logic        valid;
  logic        busy;
  logic [2:0]  dbg_state;
  logic [31:0] nib;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  adc_scan_capture_if adc_if ();

  adc_scan_capture #(
    .CLK_DIV     (CLK_DIV),
    .SCAN_PERIOD (SCAN_PERIOD)
  ) dut (
    .iCLK_50MHZ  (clk),
    .iRST_N      (rst_n),
    .adc         (adc_if),
    .VinH        (VinH),
    .VinL        (VinL),
    .VoutH       (VoutH),
    .VoutL       (VoutL),
    .IoutH       (IoutH),
    .IoutL       (IoutL),
    .TempH       (TempH),
    .TempL       (TempL),
    .oVALID      (valid),
    .oBUSY       (busy),
    .dbg_state_o (dbg_state)
  );

  assign nib = {VinH, VinL, VoutH, VoutL, IoutH, IoutL, TempH, TempL};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: answers each frame with the code of the channel addressed in the previous frame.
  logic [11:0] code [8];
  logic [2:0]  exp_addr [5];
  logic [15:0] tx_sr;
  logic [15:0] rx_sr;
  logic [2:0]  prev_addr = 3'd0;
  bit          in_frame = 1'b0;
  int          fall_cnt = 0;
  int          fidx = 0;
  int          frame_err = 0;

  always @(negedge adc_if.oADC_CS_N) begin
    in_frame = 1'b1;
    fall_cnt = 0;
    rx_sr    = '0;
    tx_sr    = {4'b0000, code[prev_addr]};
  end

  always @(negedge adc_if.oADC_SCLK) begin
    if (adc_if.oADC_CS_N === 1'b0) begin
      adc_if.iADC_DOUT = tx_sr[15];
      tx_sr            = {tx_sr[14:0], 1'b0};
      fall_cnt++;
    end
  end

  always @(posedge adc_if.oADC_SCLK) begin
    if (adc_if.oADC_CS_N === 1'b0) rx_sr = {rx_sr[14:0], adc_if.oADC_DIN};
  end

  always @(posedge busy) fidx = 0;

  always @(posedge adc_if.oADC_CS_N) begin
    if (in_frame) begin
      in_frame = 1'b0;
      if (rst_n) begin
        if (fidx < 5) begin
          if (fall_cnt != 16 || rx_sr[13:11] != exp_addr[fidx] || (rx_sr & 16'hC7FF) != 16'h0000)
            frame_err++;
        end else begin
          frame_err++;
        end
        prev_addr = rx_sr[13:11];
        fidx++;
      end
    end
  end

  // Output monitor: nibbles may only move on an oVALID cycle; SCLK must idle high while deselected.
  logic [31:0] last_out = '0;
  int          hold_err = 0;
  int          sclk_err = 0;
  int          valid_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_out = '0;
    end else if (valid === 1'b1) begin
      last_out = nib;
      valid_cnt++;
    end else if (nib !== last_out) begin
      hold_err++;
    end
    if (adc_if.oADC_CS_N === 1'b1 && adc_if.oADC_SCLK !== 1'b1) sclk_err++;
  end

  // Reference: each channel shows the top 8 of its 12-bit code.
  function automatic logic [31:0] ref_nibbles(input logic [11:0] a, b, c, d);
    return {a[11:4], b[11:4], c[11:4], d[11:4]};
  endfunction

  // Driver tasks
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic apply_codes(input vec_t v);
    code[0] = v.vin;
    code[1] = v.vout;
    code[2] = v.iout;
    code[3] = v.temp;
    for (int c = 4; c < 8; c++) code[c] = 12'($urandom_range(0, 4095));
  endtask

  task automatic wait_valid(input string name, output int at);
    int n;
    n = 0;
    @(negedge clk);
    while (valid !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: no oVALID within %0d cycles", name, BUDGET);
    end
    at = cyc;
  endtask

  task automatic wait_busy(input logic lvl);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== lvl && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (busy !== lvl) begin
      checks++;
      errors++;
      $display("FAIL wait_busy: busy stuck at %b, wanted %b", busy, lvl);
    end
  endtask

  task automatic wait_mid_frame();
    int n;
    n = 0;
    while (!(in_frame && fidx == 2 && fall_cnt >= 8) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (!(in_frame && fidx == 2 && fall_cnt >= 8)) begin
      checks++;
      errors++;
      $display("FAIL wait_mid_frame: frame 2 bit 7 not reached, fidx=%0d falls=%0d", fidx, fall_cnt);
    end
  endtask

  // Watchdog
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // Test sequence
  vec_t vecs [NV];
  vec_t mid;
  int   at;
  int   prev_at;
  int   rel;

  initial begin
    exp_addr = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3};
    vecs[0] = '{12'hA5C, 12'h3F0, 12'h07F, 12'hFFF, 32'hA53F07FF};
    vecs[1] = '{12'h000, 12'h000, 12'h000, 12'h000, 32'h00000000};
    vecs[2] = '{12'h00F, 12'h010, 12'hFF0, 12'h800, 32'h0001FF80};
    for (int i = 3; i < NV; i++) begin
      vecs[i].vin  = 12'($urandom_range(0, 4095));
      vecs[i].vout = 12'($urandom_range(0, 4095));
      vecs[i].iout = 12'($urandom_range(0, 4095));
      vecs[i].temp = 12'($urandom_range(0, 4095));
      vecs[i].exp  = ref_nibbles(vecs[i].vin, vecs[i].vout, vecs[i].iout, vecs[i].temp);
    end

    rst_n = 1'b0;
    apply_codes(vecs[0]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n",  32'(adc_if.oADC_CS_N), 32'd1);
    check("rst_sclk",  32'(adc_if.oADC_SCLK), 32'd1);
    check("rst_din",   32'(adc_if.oADC_DIN), 32'd0);
    check("rst_nib",   nib, 32'h0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);

    @(posedge clk);
    #1 rst_n = 1'b1;
    rel     = cyc;
    prev_at = rel;

    // Table: one commit per row, codes changed during IDLE right after the previous commit.
    for (int i = 0; i < NV; i++) begin
      wait_valid($sformatf("valid_row%0d", i), at);
      check($sformatf("gap_row%0d", i), 32'(at - prev_at), (i == 0) ? 32'(FIRST_VALID) : 32'(VALID_GAP));
      check($sformatf("nib_row%0d", i), nib, vecs[i].exp);
      check($sformatf("frames_row%0d", i), 32'(frame_err), 32'd0);
      prev_at = at;
      @(negedge clk);
      check($sformatf("pulse_row%0d", i), 32'(valid), 32'd0);
      if (i + 1 < NV) apply_codes(vecs[i + 1]);
    end

    // Reset during frame 2, bit 7: frame aborts, outputs hold until the reset edge.
    mid.vin  = 12'($urandom_range(0, 4095));
    mid.vout = 12'($urandom_range(0, 4095));
    mid.iout = 12'($urandom_range(0, 4095));
    mid.temp = 12'($urandom_range(0, 4095));
    mid.exp  = ref_nibbles(mid.vin, mid.vout, mid.iout, mid.temp);
    apply_codes(mid);
    wait_mid_frame();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("pre_reset_nib",  nib, vecs[NV-1].exp);
    check("pre_reset_cs_n", 32'(adc_if.oADC_CS_N), 32'd0);
    @(negedge clk);
    check("mid_rst_pins", 32'({adc_if.oADC_CS_N, adc_if.oADC_SCLK, adc_if.oADC_DIN, valid, busy}), 32'b11000);
    check("mid_rst_nib",  nib, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rel = cyc;
    wait_valid("valid_after_mid_rst", at);
    check("gap_after_mid_rst",    32'(at - rel), 32'(FIRST_VALID));
    check("nib_after_mid_rst",    nib, mid.exp);
    check("frames_after_mid_rst", 32'(frame_err), 32'd0);

`ifdef ADC_SCAN_AVG_EN
    begin : avg_seq
      logic [11:0] vseq [4];
      int          vc0;
      int          sum;
      vseq = '{12'h100, 12'h200, 12'h300, 12'h410};
      sum  = 0;
      for (int k = 0; k < 4; k++) sum += int'(vseq[k][11:4]);
      code[0] = vseq[0];
      code[1] = 12'h123;
      code[2] = 12'h456;
      code[3] = 12'h789;
      wait_busy(1'b0);
      vc0 = valid_cnt;
      for (int k = 1; k < 4; k++) begin
        wait_busy(1'b1);
        wait_busy(1'b0);
        code[0] = vseq[k];
      end
      wait_valid("avg_valid", at);
      check("avg_nib", nib, {8'(sum / 4), 8'h12, 8'h45, 8'h78});
      check("avg_vin_spec", {24'h0, nib[31:24]}, 32'h28);
      @(negedge clk);
      check("avg_valid_count", 32'(valid_cnt - vc0), 32'd1);
    end
`endif

    check("hold_between_commits", 32'(hold_err), 32'd0);
    check("sclk_high_when_deselected", 32'(sclk_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
